gen_frame_sequencer: RTL
========================

Name: gen_frame_sequencer

Overview:
Hardware frame scheduler that owns generator_v3. It accepts a pixel stream from an upstream source and gates exactly IN_PIXELS samples per frame into the generator. It then waits a fixed pipeline-drain window, pulses the generator's reset, and re-arms for the next frame. On the output side it forwards only the first OUT_PIXELS valid results per frame, marks the last one, and discards flush residue.

Parameters:
DATA_WIDTH, 16, pixel/sample width (signed)
IN_PIXELS, 1024, input samples per frame (32x32)
OUT_PIXELS, 784, output samples forwarded per frame (28x28)
DRAIN_CYCLES, 35000, cycles spent in DRAIN after the last input
RST_CYCLES, 100, cycles gen_rst_n is held low between frames
REC_CYCLES, 100, cycles after gen_rst_n release before accepting input

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  upstream sample valid
s_ready  out  1  sequencer can accept a sample
s_data  in  DATA_WIDTH  upstream sample (signed)
gen_rst_n  out  1  reset to generator_v3 (active-low, registered)
gen_valid_in  out  1  to generator valid_in (registered)
gen_data_in  out  DATA_WIDTH  to generator data_in (registered)
gen_valid_out  in  1  from generator valid_out
gen_data_out  in  DATA_WIDTH  from generator data_out
m_valid  out  1  forwarded output valid (registered)
m_data  out  DATA_WIDTH  forwarded output data
m_last  out  1  high with the OUT_PIXELS-th forwarded sample
frame_done  out  1  one-cycle pulse on DRAIN->RST transition
frame_short  out  1  one-cycle pulse with frame_done when fewer than OUT_PIXELS were forwarded
frame_cnt  out  16  completed frames, wraps at 65535->0

Behaviour:
- Reset (async, rst_n=0): state=RECOVER, phase counter=0, in_cnt=0, out_cnt=0, frame_cnt=0. gen_rst_n=0, s_ready=0, gen_valid_in=0, gen_data_in=0, m_valid=0, m_data=0, m_last=0, frame_done=0, frame_short=0.
- States: RECOVER -> LOAD -> DRAIN -> RST -> RECOVER.
- RECOVER:
  - gen_rst_n=1 from the first clock after rst_n release.
  - Count REC_CYCLES cycles, then go to LOAD.
  - On exit, clear in_cnt and out_cnt.
- LOAD:
  - s_ready=1 combinationally; it is 0 in all other states.
  - A sample is accepted on a clock where s_valid&&s_ready.
  - The next cycle, gen_valid_in=1 and gen_data_in=s_data (1-cycle latency). Otherwise gen_valid_in=0 and gen_data_in holds its value.
  - Accepting the IN_PIXELS-th sample moves the state to DRAIN on the same edge, so at most IN_PIXELS samples are accepted per frame.
  - Upstream bubbles (s_valid=0) are legal and only stall counting.
- DRAIN:
  - No input is accepted; gen_valid_in=0 from the second DRAIN cycle onward.
  - Count DRAIN_CYCLES cycles, then go to RST.
  - The exit cycle pulses frame_done, pulses frame_short if out_cnt<OUT_PIXELS, and increments frame_cnt.
- RST:
  - gen_rst_n=0 for exactly RST_CYCLES cycles (registered: low from the first RST cycle).
  - Then go to RECOVER.
- Output filter, active in LOAD and DRAIN only:
  - If gen_valid_out && out_cnt<OUT_PIXELS: next cycle m_valid=1, m_data=gen_data_out, out_cnt increments, and m_last=1 when that sample is number OUT_PIXELS.
  - Otherwise m_valid=0 and m_last=0.
  - gen_valid_out in RST or RECOVER is ignored.
  - Samples beyond OUT_PIXELS are dropped silently.
- No backpressure on the m_ output.
- Counter widths: $clog2(max+1). DRAIN_CYCLES must fit 17 bits.
- Reset mid-frame: immediate abort to the reset state. No frame_done, and the partial frame's outputs are not completed.
- A sample offered on the DRAIN-entry edge is not accepted (s_ready is already 0).

Test Plan:
Use IN_PIXELS=8, OUT_PIXELS=5, DRAIN_CYCLES=20, RST_CYCLES=3, REC_CYCLES=4 with a behavioral generator model.
1. Reset release -> gen_rst_n=1 on the first edge; s_ready rises exactly 4 cycles later; all other outputs 0.
2. Continuous s_valid with data 1..10 -> only 1..8 reach gen_data_in on consecutive cycles, each 1 cycle after acceptance; s_ready drops after the 8th; samples 9 and 10 stay pending.
3. Model emits 7 outputs (100..106) during the frame -> m_data=100..104, m_last with 104, 105 and 106 dropped; frame_done after 20 DRAIN cycles with frame_short=0; frame_cnt=1.
4. Model emits only 3 outputs -> frame_done and frame_short pulse together; gen_rst_n low exactly 3 cycles; next LOAD starts with out_cnt=0.
5. gen_valid_out asserted during RST/RECOVER -> m_valid stays 0.
6. rst_n asserted mid-LOAD after 4 samples -> all outputs return to reset values asynchronously; after release, the next frame accepts 8 fresh samples and frame_cnt is 0.

Source files
------------

// File: rtl/gen_frame_sequencer.sv
// Frame scheduler for generator_v3: gates IN_PIXELS samples per frame, drains, resets the generator, re-arms.
// Input and output paths are 1-cycle registered; upstream is stalled via s_ready outside LOAD; m_ has no backpressure.
module gen_frame_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int IN_PIXELS    = 1024,
  parameter int OUT_PIXELS   = 784,
  parameter int DRAIN_CYCLES = 35000,
  parameter int RST_CYCLES   = 100,
  parameter int REC_CYCLES   = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  gen_rst_n,
  output logic                  gen_valid_in,
  output logic [DATA_WIDTH-1:0] gen_data_in,
  input  logic                  gen_valid_out,
  input  logic [DATA_WIDTH-1:0] gen_data_out,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  frame_done,
  output logic                  frame_short,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [1:0] {
    ST_RECOVER = 2'd0,
    ST_LOAD    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RST     = 2'd3
  } state_t;

  localparam int PH_MAX = (DRAIN_CYCLES > RST_CYCLES)
                        ? ((DRAIN_CYCLES > REC_CYCLES) ? DRAIN_CYCLES : REC_CYCLES)
                        : ((RST_CYCLES > REC_CYCLES) ? RST_CYCLES : REC_CYCLES);
  localparam int PH_W  = $clog2(PH_MAX + 1);
  localparam int IN_W  = $clog2(IN_PIXELS + 1);
  localparam int OUT_W = $clog2(OUT_PIXELS + 1);

  localparam logic [PH_W-1:0]  REC_LAST   = PH_W'(REC_CYCLES - 1);
  localparam logic [PH_W-1:0]  DRAIN_LAST = PH_W'(DRAIN_CYCLES - 1);
  localparam logic [PH_W-1:0]  RST_LAST   = PH_W'(RST_CYCLES - 1);
  localparam logic [IN_W-1:0]  IN_LAST    = IN_W'(IN_PIXELS - 1);
  localparam logic [OUT_W-1:0] OUT_LAST   = OUT_W'(OUT_PIXELS - 1);
  localparam logic [OUT_W-1:0] OUT_MAX    = OUT_W'(OUT_PIXELS);

  state_t           state;
  logic [PH_W-1:0]  phase;
  logic [IN_W-1:0]  in_cnt;
  logic [OUT_W-1:0] out_cnt;

  logic             accept;
  logic             out_take;
  logic [OUT_W-1:0] out_cnt_nxt;

  assign s_ready     = (state == ST_LOAD);
  assign accept      = s_valid && s_ready;
  // Generator results only count while a frame is live; anything after OUT_PIXELS is flush residue.
  assign out_take    = gen_valid_out && ((state == ST_LOAD) || (state == ST_DRAIN)) && (out_cnt < OUT_MAX);
  assign out_cnt_nxt = out_cnt + OUT_W'(out_take);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RECOVER;
      phase        <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      frame_cnt    <= '0;
      gen_rst_n    <= 1'b0;
      gen_valid_in <= 1'b0;
      gen_data_in  <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      frame_done   <= 1'b0;
      frame_short  <= 1'b0;
    end else begin
      gen_valid_in <= accept;
      if (accept) gen_data_in <= s_data;

      m_valid <= out_take;
      m_last  <= out_take && (out_cnt == OUT_LAST);
      if (out_take) m_data <= gen_data_out;
      out_cnt <= out_cnt_nxt;

      frame_done  <= 1'b0;
      frame_short <= 1'b0;

      case (state)
        ST_RECOVER: begin
          gen_rst_n <= 1'b1;
          // Recovery time is measured from generator reset release, not from entry.
          if (gen_rst_n) begin
            if (phase == REC_LAST) begin
              state   <= ST_LOAD;
              phase   <= '0;
              in_cnt  <= '0;
              out_cnt <= '0;
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
        end

        ST_LOAD: begin
          if (accept) begin
            in_cnt <= in_cnt + IN_W'(1);
            if (in_cnt == IN_LAST) begin
              state <= ST_DRAIN;
              phase <= '0;
            end
          end
        end

        ST_DRAIN: begin
          if (phase == DRAIN_LAST) begin
            state       <= ST_RST;
            phase       <= '0;
            gen_rst_n   <= 1'b0;
            frame_done  <= 1'b1;
            frame_short <= (out_cnt_nxt < OUT_MAX);
            frame_cnt   <= frame_cnt + 16'd1;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end

        ST_RST: begin
          if (phase == RST_LAST) begin
            state     <= ST_RECOVER;
            phase     <= '0;
            gen_rst_n <= 1'b1;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end

        default: state <= ST_RECOVER;
      endcase
    end
  end

endmodule
